// File: rtl/spell_sram_responder_pkg.sv
// -----------------------------------------------------------------------------
// spell_sram_responder_pkg
//
// Shared definitions for the spell SRAM responder slice.
//   - sram_state_t    : responder FSM state encoding (3 bits)
//   - SPELL_SRAM_BASE : default byte base of the SRAM window; spell_mem's
//                       master side decodes against the same constant
//   - SPELL_SRAM_MAX_WAIT : largest wait-state count the 4-bit counter holds
//   - macro_touched() : whether a request actually needs a macro cycle
// -----------------------------------------------------------------------------
package spell_sram_responder_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ACCESS = 3'd1,
      WAIT   = 3'd2,
      RESP   = 3'd3,
      ERR    = 3'd4
   } sram_state_t;

   localparam logic [31:0] SPELL_SRAM_BASE = 32'h3000_0000;

   localparam int SPELL_SRAM_MAX_WAIT = 15;

   // A read always touches the macro. A write touches it only when at least
   // one byte lane is selected; an all-zero select is acked without ever
   // pulling chip select low.
   function automatic logic macro_touched(input logic we, input logic [3:0] sel);
      return (!we) || (sel != 4'b0000);
   endfunction

endpackage

// File: rtl/spell_sram_decode.sv
// -----------------------------------------------------------------------------
// spell_sram_decode
//
// Purely combinational window decode for the spell SRAM responder. Takes the
// word part of a Wishbone byte address (byte-lane bits already stripped) and
// reports whether it falls in the BASE_ADDR window, plus the macro word index.
// Kept separate so a scoreboard can reuse the exact same decode.
//
// Parameters:
//   ADDR_WIDTH : macro word-address width
//   BASE_ADDR  : byte base of the window, aligned to 2**(ADDR_WIDTH+2)
//
// Ports:
//   word_adr  in  30          Wishbone address bits [31:2]
//   hit       out 1           address lies inside the window
//   word_idx  out ADDR_WIDTH  macro word address
// -----------------------------------------------------------------------------
module spell_sram_decode
   import spell_sram_responder_pkg::*;
#(
   parameter int          ADDR_WIDTH = 8,
   parameter logic [31:0] BASE_ADDR  = SPELL_SRAM_BASE
) (
   input  logic [29:0]           word_adr,
   output logic                  hit,
   output logic [ADDR_WIDTH-1:0] word_idx
);

   // Only the base bits above the window size take part in the compare; the
   // lower base bits are zero by the alignment rule and are ignored here.
   localparam logic [31:0] BASE_WORD = BASE_ADDR >> 2;
   localparam logic [29-ADDR_WIDTH:0] BASE_TAG = BASE_WORD[29:ADDR_WIDTH];

   // The upper address bits select the window; the lower ones select the word.
   always_comb begin
      hit      = (word_adr[29:ADDR_WIDTH] == BASE_TAG);
      word_idx = word_adr[ADDR_WIDTH-1:0];
   end

endmodule

// File: rtl/spell_sram_responder.sv
// -----------------------------------------------------------------------------
// spell_sram_responder
//
// Wishbone classic slave sitting behind the spell core's OpenRAM master port.
// Each Wishbone cycle inside the BASE_ADDR window becomes exactly one access
// on an OpenRAM-style single-port synchronous SRAM macro (active-low chip
// select and write enable, byte write mask). Reads return the macro data with
// a one-cycle ack; addresses outside the window get a one-cycle err instead.
// WAIT_STATES adds programmable latency between the macro access and the ack.
//
// Parameters:
//   ADDR_WIDTH  : macro word-address width (depth 2**ADDR_WIDTH words)
//   BASE_ADDR   : byte base of the window, aligned to 2**(ADDR_WIDTH+2)
//   WAIT_STATES : extra cycles (0..15) between macro access and ack
//
// Ports:
//   clock, reset         system clock, synchronous active-high reset
//   wb_cyc_i, wb_stb_i   Wishbone cycle / strobe
//   wb_we_i, wb_sel_i    write enable, byte selects
//   wb_adr_i, wb_dat_i   byte address, write data
//   wb_dat_o             registered read data
//   wb_ack_o, wb_err_o   one-cycle completion / decode-error pulses
//   ram_csb_o, ram_web_o macro chip select / write enable (active low)
//   ram_wmask_o          macro byte write mask
//   ram_addr_o           macro word address
//   ram_din_o            macro write data
//   ram_dout_i           macro read data
//   wp_i                 write protect (only with SPELL_SRAM_WRITE_PROTECT_EN)
//
// Build option:
//   SPELL_SRAM_WRITE_PROTECT_EN : adds wp_i; in-window writes while wp_i=1
//                                 take the error path without a macro access.
// -----------------------------------------------------------------------------
module spell_sram_responder
   import spell_sram_responder_pkg::*;
#(
   parameter int          ADDR_WIDTH  = 8,
   parameter logic [31:0] BASE_ADDR   = SPELL_SRAM_BASE,
   parameter int          WAIT_STATES = 0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  wb_cyc_i,
   input  logic                  wb_stb_i,
   input  logic                  wb_we_i,
   input  logic [3:0]            wb_sel_i,
   input  logic [31:0]           wb_adr_i,
   input  logic [31:0]           wb_dat_i,
   output logic [31:0]           wb_dat_o,
   output logic                  wb_ack_o,
   output logic                  wb_err_o,
`ifdef SPELL_SRAM_WRITE_PROTECT_EN
   input  logic                  wp_i,
`endif
   output logic                  ram_csb_o,
   output logic                  ram_web_o,
   output logic [3:0]            ram_wmask_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic [31:0]           ram_din_o,
   input  logic [31:0]           ram_dout_i
);

   // The counter is loaded on the way into WAIT and the final WAIT cycle is
   // the one that sees zero, so the load value is one less than the count.
   localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   sram_state_t           state_q, state_d;
   logic [3:0]            wait_cnt_q, wait_cnt_d;
   logic                  rd_q, rd_d;
   logic [31:0]           dat_q, dat_d;
   logic                  ack_q, ack_d;
   logic                  err_q, err_d;
   logic                  csb_q, csb_d;
   logic                  web_q, web_d;
   logic [3:0]            wmask_q, wmask_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           din_q, din_d;

   logic                  win_hit;
   logic [ADDR_WIDTH-1:0] word_idx;
   logic                  wp_block;
   logic [1:0]            unused_byte_bits;

   assign unused_byte_bits = wb_adr_i[1:0];

   spell_sram_decode #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .BASE_ADDR  (BASE_ADDR)
   ) u_decode (
      .word_adr (wb_adr_i[31:2]),
      .hit      (win_hit),
      .word_idx (word_idx)
   );

   // Write protect turns an otherwise valid write into a decode-style error.
   // Without the build option nothing is ever blocked.
`ifdef SPELL_SRAM_WRITE_PROTECT_EN
   assign wp_block = wp_i && wb_we_i;
`else
   assign wp_block = 1'b0;
`endif

   // State and every output are plain registers; reset drives all of them to
   // their idle values on the same edge, even in the middle of a transfer.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         wait_cnt_q <= 4'd0;
         rd_q       <= 1'b0;
         dat_q      <= 32'd0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         csb_q      <= 1'b1;
         web_q      <= 1'b1;
         wmask_q    <= 4'd0;
         addr_q     <= '0;
         din_q      <= 32'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         rd_q       <= rd_d;
         dat_q      <= dat_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         csb_q      <= csb_d;
         web_q      <= web_d;
         wmask_q    <= wmask_d;
         addr_q     <= addr_d;
         din_q      <= din_d;
      end
   end

   // Next-state and next-output logic. ack and err default low so they can
   // only ever be single-cycle pulses. The macro controls are set when IDLE
   // accepts a request and dropped again when leaving ACCESS, so the macro
   // sees exactly one cycle of chip select per transfer. Read data is taken
   // from the macro on the edge that enters RESP, whether that edge comes
   // straight from ACCESS or from the last WAIT cycle. Dropping cyc while in
   // ACCESS or WAIT abandons the transfer with no response at all.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      rd_d       = rd_q;
      dat_d      = dat_q;
      ack_d      = 1'b0;
      err_d      = 1'b0;
      csb_d      = csb_q;
      web_d      = web_q;
      wmask_d    = wmask_q;
      addr_d     = addr_q;
      din_d      = din_q;

      case (state_q)
         IDLE: begin
            if (wb_cyc_i && wb_stb_i) begin
               if (win_hit && !wp_block) begin
                  state_d = ACCESS;
                  addr_d  = word_idx;
                  rd_d    = !wb_we_i;
                  csb_d   = !macro_touched(wb_we_i, wb_sel_i);
                  if (wb_we_i) begin
                     web_d   = 1'b0;
                     wmask_d = wb_sel_i;
                     din_d   = wb_dat_i;
                  end else begin
                     web_d   = 1'b1;
                     wmask_d = 4'd0;
                  end
               end else begin
                  state_d = ERR;
                  err_d   = 1'b1;
               end
            end
         end

         ACCESS: begin
            csb_d   = 1'b1;
            web_d   = 1'b1;
            wmask_d = 4'd0;
            if (!wb_cyc_i) begin
               state_d = IDLE;
            end else if (WAIT_STATES > 0) begin
               state_d    = WAIT;
               wait_cnt_d = WAIT_LOAD;
            end else begin
               state_d = RESP;
               ack_d   = 1'b1;
               if (rd_q) begin
                  dat_d = ram_dout_i;
               end
            end
         end

         WAIT: begin
            if (!wb_cyc_i) begin
               state_d    = IDLE;
               wait_cnt_d = 4'd0;
            end else if (wait_cnt_q == 4'd0) begin
               state_d = RESP;
               ack_d   = 1'b1;
               if (rd_q) begin
                  dat_d = ram_dout_i;
               end
            end else begin
               wait_cnt_d = wait_cnt_q - 4'd1;
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         ERR: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign wb_dat_o    = dat_q;
   assign wb_ack_o    = ack_q;
   assign wb_err_o    = err_q;
   assign ram_csb_o   = csb_q;
   assign ram_web_o   = web_q;
   assign ram_wmask_o = wmask_q;
   assign ram_addr_o  = addr_q;
   assign ram_din_o   = din_q;

endmodule

// File: tb/tb_spell_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_spell_sram_responder
//
// Directed bench for spell_sram_responder. Two instances share one Wishbone
// bus (each with its own cyc): dut_a with WAIT_STATES=0 and dut_b with
// WAIT_STATES=3, each backed by a small behavioural macro model. Expected
// values are hand-computed constants. Build with SPELL_SRAM_WRITE_PROTECT_EN
// to add the write-protect steps.
// -----------------------------------------------------------------------------
module tb_spell_sram_responder;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cyc_a = 1'b0;
   logic        cyc_b = 1'b0;
   logic        stb   = 1'b0;
   logic        we    = 1'b0;
   logic [3:0]  sel   = 4'd0;
   logic [31:0] adr   = 32'd0;
   logic [31:0] wdat  = 32'd0;
`ifdef SPELL_SRAM_WRITE_PROTECT_EN
   logic        wp    = 1'b0;
`endif

   logic [31:0] dat_a, dat_b;
   logic        ack_a, ack_b, err_a, err_b;
   logic        csb_a, csb_b, web_a, web_b;
   logic [3:0]  wmask_a, wmask_b;
   logic [7:0]  addr_a, addr_b;
   logic [31:0] din_a, din_b, dout_a, dout_b;

   logic [31:0] mem_a [256];
   logic [31:0] mem_b [256];

   int vectors     = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   spell_sram_responder #(.ADDR_WIDTH(8), .BASE_ADDR(32'h3000_0000), .WAIT_STATES(0)) dut_a (
      .clock(clock), .reset(reset),
      .wb_cyc_i(cyc_a), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel),
      .wb_adr_i(adr), .wb_dat_i(wdat),
      .wb_dat_o(dat_a), .wb_ack_o(ack_a), .wb_err_o(err_a),
`ifdef SPELL_SRAM_WRITE_PROTECT_EN
      .wp_i(wp),
`endif
      .ram_csb_o(csb_a), .ram_web_o(web_a), .ram_wmask_o(wmask_a),
      .ram_addr_o(addr_a), .ram_din_o(din_a), .ram_dout_i(dout_a)
   );

   spell_sram_responder #(.ADDR_WIDTH(8), .BASE_ADDR(32'h3000_0000), .WAIT_STATES(3)) dut_b (
      .clock(clock), .reset(reset),
      .wb_cyc_i(cyc_b), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel),
      .wb_adr_i(adr), .wb_dat_i(wdat),
      .wb_dat_o(dat_b), .wb_ack_o(ack_b), .wb_err_o(err_b),
`ifdef SPELL_SRAM_WRITE_PROTECT_EN
      .wp_i(wp),
`endif
      .ram_csb_o(csb_b), .ram_web_o(web_b), .ram_wmask_o(wmask_b),
      .ram_addr_o(addr_b), .ram_din_o(din_b), .ram_dout_i(dout_b)
   );

   // Macro models: byte-masked write on an edge that sees chip select and
   // write enable low; read data follows the registered address.
   always @(posedge clock) begin
      if (!csb_a && !web_a) begin
         for (int b = 0; b < 4; b++) begin
            if (wmask_a[b]) mem_a[addr_a][8*b +: 8] <= din_a[8*b +: 8];
         end
      end
      if (!csb_b && !web_b) begin
         for (int b = 0; b < 4; b++) begin
            if (wmask_b[b]) mem_b[addr_b][8*b +: 8] <= din_b[8*b +: 8];
         end
      end
   end

   assign dout_a = mem_a[addr_a];
   assign dout_b = mem_b[addr_b];

   // Advance one edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input int dut, input logic on, input logic w,
                                input logic [3:0] s, input logic [31:0] a,
                                input logic [31:0] d);
      cyc_a = (dut == 0) ? on : 1'b0;
      cyc_b = (dut == 1) ? on : 1'b0;
      stb   = on;
      we    = w;
      sel   = s;
      adr   = a;
      wdat  = d;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Runs one transfer and reports, per observation after each edge (1 = just
   // after the sampling edge), where ack/err first appeared, how many cycles
   // chip select was low, the address/mask seen while it was low, and
   // whether ack/err were still high one cycle after the pulse.
   task automatic busCycle(input int dut, input logic w, input logic [3:0] s,
                           input logic [31:0] a, input logic [31:0] d,
                           output int ack_at, output int err_at, output int csb_low,
                           output logic [7:0] addr_seen, output logic [3:0] wmask_seen,
                           output logic [1:0] tail, output logic [31:0] rdat);
      logic a_ack, a_err, a_csb;
      ack_at = -1; err_at = -1; csb_low = 0; addr_seen = 8'hxx; wmask_seen = 4'hx;
      applyStimulus(dut, 1'b1, w, s, a, d);
      for (int i = 1; i <= 12 && ack_at < 0 && err_at < 0; i++) begin
         tick();
         a_ack = (dut == 0) ? ack_a : ack_b;
         a_err = (dut == 0) ? err_a : err_b;
         a_csb = (dut == 0) ? csb_a : csb_b;
         if (!a_csb) begin
            csb_low++;
            addr_seen  = (dut == 0) ? addr_a : addr_b;
            wmask_seen = (dut == 0) ? wmask_a : wmask_b;
         end
         if (a_ack) ack_at = i;
         if (a_err) err_at = i;
      end
      applyStimulus(dut, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
      tick();
      tail = (dut == 0) ? {ack_a, err_a} : {ack_b, err_b};
      rdat = (dut == 0) ? dat_a : dat_b;
   endtask

   initial begin
      int          ack_at, err_at, csb_low, ack_count;
      logic [7:0]  addr_seen;
      logic [3:0]  wmask_seen;
      logic [1:0]  tail;
      logic [31:0] rdat;

      $display("[TB] start");

      // Reset values
      tick(); tick();
      checkOutput("rst_dat",   dat_a,   32'd0);
      checkOutput("rst_ack",   {31'd0, ack_a}, 32'd0);
      checkOutput("rst_err",   {31'd0, err_a}, 32'd0);
      checkOutput("rst_csb",   {31'd0, csb_a}, 32'd1);
      checkOutput("rst_web",   {31'd0, web_a}, 32'd1);
      checkOutput("rst_wmask", {28'd0, wmask_a}, 32'd0);
      checkOutput("rst_addr",  {24'd0, addr_a}, 32'd0);
      checkOutput("rst_din",   din_a,   32'd0);
      reset = 1'b0;
      tick();

      // Full-word write then read, no wait states
      busCycle(0, 1'b1, 4'hF, 32'h3000_0010, 32'hDEADBEEF, ack_at, err_at, csb_low, addr_seen, wmask_seen, tail, rdat);
      checkOutput("wr_ack_at",  ack_at, 32'd2);
      checkOutput("wr_err_at",  err_at, 32'hFFFF_FFFF);
      checkOutput("wr_csb_low", csb_low, 32'd1);
      checkOutput("wr_addr",    {24'd0, addr_seen}, 32'd4);
      checkOutput("wr_wmask",   {28'd0, wmask_seen}, 32'hF);
      checkOutput("wr_tail",    {30'd0, tail}, 32'd0);
      busCycle(0, 1'b0, 4'hF, 32'h3000_0010, 32'd0, ack_at, err_at, csb_low, addr_seen, wmask_seen, tail, rdat);
      checkOutput("rd_ack_at",  ack_at, 32'd2);
      checkOutput("rd_data",    rdat, 32'hDEADBEEF);
      checkOutput("rd_wmask",   {28'd0, wmask_seen}, 32'h0);

      // Byte mask
      busCycle(0, 1'b1, 4'hF, 32'h3000_0010, 32'h0000_0000, ack_at, err_at, csb_low, addr_seen, wmask_seen, tail, rdat);
      checkOutput("pre_ack_at", ack_at, 32'd2);
      checkOutput("pre_keeps_dat", rdat, 32'hDEADBEEF);
      busCycle(0, 1'b1, 4'b0101, 32'h3000_0010, 32'hAABBCCDD, ack_at, err_at, csb_low, addr_seen, wmask_seen, tail, rdat);
      checkOutput("bm_wmask",   {28'd0, wmask_seen}, 32'h5);
      busCycle(0, 1'b0, 4'hF, 32'h3000_0010, 32'd0, ack_at, err_at, csb_low, addr_seen, wmask_seen, tail, rdat);
      checkOutput("bm_rd_data", rdat, 32'h00BB00DD);

      // Write with no byte selected: acked, macro untouched
      busCycle(0, 1'b1, 4'h0, 32'h3000_0010, 32'h1234_5678, ack_at, err_at, csb_low, addr_seen, wmask_seen, tail, rdat);
      checkOutput("sel0_csb_low", csb_low, 32'd0);
      checkOutput("sel0_ack_at",  ack_at, 32'd2);
      busCycle(0, 1'b0, 4'hF, 32'h3000_0010, 32'd0, ack_at, err_at, csb_low, addr_seen, wmask_seen, tail, rdat);
      checkOutput("sel0_rd_data", rdat, 32'h00BB00DD);

      // Decode errors just above and just below the window
      busCycle(0, 1'b0, 4'hF, 32'h3000_0400, 32'd0, ack_at, err_at, csb_low, addr_seen, wmask_seen, tail, rdat);
      checkOutput("err_hi_err_at",  err_at, 32'd1);
      checkOutput("err_hi_ack_at",  ack_at, 32'hFFFF_FFFF);
      checkOutput("err_hi_csb_low", csb_low, 32'd0);
      checkOutput("err_hi_tail",    {30'd0, tail}, 32'd0);
      busCycle(0, 1'b1, 4'hF, 32'h2FFF_FFFC, 32'h5555_5555, ack_at, err_at, csb_low, addr_seen, wmask_seen, tail, rdat);
      checkOutput("err_lo_err_at",  err_at, 32'd1);
      checkOutput("err_lo_csb_low", csb_low, 32'd0);

      // Top word of the window, byte-lane address bits ignored
      busCycle(0, 1'b1, 4'hF, 32'h3000_03FF, 32'hCAFE_F00D, ack_at, err_at, csb_low, addr_seen, wmask_seen, tail, rdat);
      checkOutput("top_addr",   {24'd0, addr_seen}, 32'd255);
      busCycle(0, 1'b0, 4'hF, 32'h3000_03FC, 32'd0, ack_at, err_at, csb_low, addr_seen, wmask_seen, tail, rdat);
      checkOutput("top_rd_data", rdat, 32'hCAFE_F00D);

      // Three wait states
      busCycle(1, 1'b1, 4'hF, 32'h3000_0020, 32'h1122_3344, ack_at, err_at, csb_low, addr_seen, wmask_seen, tail, rdat);
      checkOutput("ws_wr_ack_at",  ack_at, 32'd5);
      checkOutput("ws_wr_csb_low", csb_low, 32'd1);
      busCycle(1, 1'b0, 4'hF, 32'h3000_0020, 32'd0, ack_at, err_at, csb_low, addr_seen, wmask_seen, tail, rdat);
      checkOutput("ws_rd_ack_at", ack_at, 32'd5);
      checkOutput("ws_rd_data",   rdat, 32'h1122_3344);
      checkOutput("ws_tail",      {30'd0, tail}, 32'd0);

      // Drop cyc during WAIT: no response, then a normal transfer
      applyStimulus(1, 1'b1, 1'b0, 4'hF, 32'h3000_0020, 32'd0);
      ack_count = 0;
      tick(); tick();
      applyStimulus(1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
      for (int i = 0; i < 8; i++) begin
         tick();
         if (ack_b || err_b) ack_count++;
      end
      checkOutput("abort_no_resp", ack_count, 32'd0);
      busCycle(1, 1'b0, 4'hF, 32'h3000_0020, 32'd0, ack_at, err_at, csb_low, addr_seen, wmask_seen, tail, rdat);
      checkOutput("abort_next_ack_at", ack_at, 32'd5);
      checkOutput("abort_next_data",   rdat, 32'h1122_3344);

      // Reset while a read is in ACCESS (dat_a currently holds CAFEF00D)
      applyStimulus(0, 1'b1, 1'b0, 4'hF, 32'h3000_0010, 32'd0);
      tick();
      checkOutput("mid_in_access_csb", {31'd0, csb_a}, 32'd0);
      reset = 1'b1;
      applyStimulus(0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
      tick();
      checkOutput("mid_rst_csb", {31'd0, csb_a}, 32'd1);
      checkOutput("mid_rst_ack", {31'd0, ack_a}, 32'd0);
      checkOutput("mid_rst_dat", dat_a, 32'd0);
      reset = 1'b0;
      tick();
      busCycle(0, 1'b0, 4'hF, 32'h3000_0010, 32'd0, ack_at, err_at, csb_low, addr_seen, wmask_seen, tail, rdat);
      checkOutput("post_rst_ack_at", ack_at, 32'd2);
      checkOutput("post_rst_data",   rdat, 32'h00BB00DD);

`ifdef SPELL_SRAM_WRITE_PROTECT_EN
      // Write protect: writes erred without a macro access, reads unaffected
      wp = 1'b0;
      busCycle(0, 1'b1, 4'hF, 32'h3000_0000, 32'h0A0A_0A0A, ack_at, err_at, csb_low, addr_seen, wmask_seen, tail, rdat);
      checkOutput("wp0_ack_at", ack_at, 32'd2);
      wp = 1'b1;
      busCycle(0, 1'b1, 4'hF, 32'h3000_0000, 32'h5555_5555, ack_at, err_at, csb_low, addr_seen, wmask_seen, tail, rdat);
      checkOutput("wp1_err_at",  err_at, 32'd1);
      checkOutput("wp1_csb_low", csb_low, 32'd0);
      busCycle(0, 1'b0, 4'hF, 32'h3000_0000, 32'd0, ack_at, err_at, csb_low, addr_seen, wmask_seen, tail, rdat);
      checkOutput("wp1_rd_ack_at", ack_at, 32'd2);
      checkOutput("wp1_rd_data",   rdat, 32'h0A0A_0A0A);
      wp = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
